pipe_ctrl_unit: RTL and testbench

//  Pipelined control unit for the 5-stage femtoRV32 core (IF/ID/EX/MEM/WB). Decodes the ID-stage opcode and

---
 rtl/pipe_ctrl_unit_pkg.sv | 78 +++++++
 rtl/pipe_ctrl_unit_if.sv | 49 ++++
 rtl/pipe_ctrl_unit_ctrl_decoder.sv | 110 +++++++++++
 rtl/pipe_ctrl_unit.sv | 129 ++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_unit_pkg.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_unit_pkg
// Shared widths, opcode table, ALU/write-back encodings and the control word
// layout for the femtoRV32 pipelined control unit.
// No ports (package).
// ----------------------------------------------------------------------------
package pipe_ctrl_unit_pkg;

    localparam int unsigned OPC_W = 5;
    localparam int unsigned RA_W  = 5;

    // inst[6:2] opcode table
    localparam logic [OPC_W-1:0] OPCODE_LOAD   = 5'b00000;
    localparam logic [OPC_W-1:0] OPCODE_FENCE  = 5'b00011;
    localparam logic [OPC_W-1:0] OPCODE_I      = 5'b00100;
    localparam logic [OPC_W-1:0] OPCODE_AUIPC  = 5'b00101;
    localparam logic [OPC_W-1:0] OPCODE_STORE  = 5'b01000;
    localparam logic [OPC_W-1:0] OPCODE_R      = 5'b01100;
    localparam logic [OPC_W-1:0] OPCODE_LUI    = 5'b01101;
    localparam logic [OPC_W-1:0] OPCODE_BRANCH = 5'b11000;
    localparam logic [OPC_W-1:0] OPCODE_JALR   = 5'b11001;
    localparam logic [OPC_W-1:0] OPCODE_JAL    = 5'b11011;
    localparam logic [OPC_W-1:0] OPCODE_SYSTEM = 5'b11100;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_R      = 2'b10;
    localparam logic [1:0] ALUOP_I      = 2'b11;

    localparam logic [1:0] MEMTOREG_ALU = 2'b00;
    localparam logic [1:0] MEMTOREG_MEM = 2'b01;
    localparam logic [1:0] MEMTOREG_PC4 = 2'b10;

    // Field order fixes bit positions: branch is the MSB, mem_to_reg[1:0] the LSBs.
    // alu_src_1 = 1 selects PC as operand A, alu_src_2 = 1 selects the immediate.
    typedef struct packed {
        logic       branch;
        logic       jump;
        logic       alu_src_1;
        logic       alu_src_2;
        logic [1:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] mem_to_reg;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);

    typedef struct packed {
        logic            valid;
        logic            halt;
        logic [RA_W-1:0] rd;
        ctrl_t           ctrl;
    } idex_t;

    typedef struct packed {
        logic            halt;
        logic [RA_W-1:0] rd;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
        logic [1:0]      mem_to_reg;
    } exmem_t;

    typedef struct packed {
        logic            halt;
        logic [RA_W-1:0] rd;
        logic            reg_write;
        logic [1:0]      mem_to_reg;
    } memwb_t;

    // All-zero control word: the bubble / NOP encoding.
    function automatic ctrl_t ctrl_nop();
        return ctrl_t'({CTRL_W{1'b0}});
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_unit_if
// Bundles the ID-stage instruction fields, EX flush and all per-stage control
// outputs of the pipelined control unit.
//   master : pipeline side, drives id_* and ex_flush, reads controls
//   slave  : control unit, reads id_* and ex_flush, drives controls
// ----------------------------------------------------------------------------
interface pipe_ctrl_unit_if;
    import pipe_ctrl_unit_pkg::*;

    logic            id_valid;
    logic [OPC_W-1:0] id_opcode;
    logic [2:0]      id_funct3;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic [RA_W-1:0] id_rd;
    logic            ex_flush;

    logic            stall;
    logic            fetch_hold;
    logic            ex_Branch;
    logic            ex_Jump;
    logic            ex_ALUSrc_1;
    logic            ex_ALUSrc_2;
    logic [1:0]      ex_ALUOp;
    logic [RA_W-1:0] ex_rd;
    logic [RA_W-1:0] mem_rd;
    logic [RA_W-1:0] wb_rd;
    logic            mem_MemRead;
    logic            mem_MemWrite;
    logic            wb_RegWrite;
    logic [1:0]      wb_MemtoReg;
    logic            halted;

    modport master (
        output id_valid, id_opcode, id_funct3, id_rs1, id_rs2, id_rd, ex_flush,
        input  stall, fetch_hold, ex_Branch, ex_Jump, ex_ALUSrc_1, ex_ALUSrc_2,
               ex_ALUOp, ex_rd, mem_rd, wb_rd, mem_MemRead, mem_MemWrite,
               wb_RegWrite, wb_MemtoReg, halted
    );

    modport slave (
        input  id_valid, id_opcode, id_funct3, id_rs1, id_rs2, id_rd, ex_flush,
        output stall, fetch_hold, ex_Branch, ex_Jump, ex_ALUSrc_1, ex_ALUSrc_2,
               ex_ALUOp, ex_rd, mem_rd, wb_rd, mem_MemRead, mem_MemWrite,
               wb_RegWrite, wb_MemtoReg, halted
    );

endinterface

// File: rtl/pipe_ctrl_unit_ctrl_decoder.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_unit_ctrl_decoder
// Purely combinational ID-stage decoder: opcode/funct3 -> control word plus
// register-use flags for hazard detection and the halt (ECALL/EBREAK) flag.
//   valid_i         ID holds a real instruction
//   opcode_i        inst[6:2]
//   funct3_i        inst[14:12]
//   ctrl_c_o        control word (all zero for NOP/unknown/invalid)
//   uses_rs1_c_o    instruction reads rs1
//   uses_rs2_c_o    instruction reads rs2
//   is_halt_c_o     SYSTEM funct3=000 with halting enabled
// ----------------------------------------------------------------------------
module pipe_ctrl_unit_ctrl_decoder
    import pipe_ctrl_unit_pkg::*;
#(
    parameter bit HALT_EN = 1'b1
) (
    input  logic             valid_i,
    input  logic [OPC_W-1:0] opcode_i,
    input  logic [2:0]       funct3_i,
    output ctrl_t            ctrl_c_o,
    output logic             uses_rs1_c_o,
    output logic             uses_rs2_c_o,
    output logic             is_halt_c_o
);

    // Opcode table
    always_comb begin
        ctrl_c_o     = ctrl_nop();
        uses_rs1_c_o = 1'b0;
        uses_rs2_c_o = 1'b0;
        is_halt_c_o  = 1'b0;
        if (valid_i) begin
            case (opcode_i)
                OPCODE_R: begin
                    ctrl_c_o.reg_write  = 1'b1;
                    ctrl_c_o.alu_op     = ALUOP_R;
                    ctrl_c_o.mem_to_reg = MEMTOREG_ALU;
                    uses_rs1_c_o        = 1'b1;
                    uses_rs2_c_o        = 1'b1;
                end
                OPCODE_I: begin
                    ctrl_c_o.reg_write  = 1'b1;
                    ctrl_c_o.alu_src_2  = 1'b1;
                    ctrl_c_o.alu_op     = ALUOP_I;
                    uses_rs1_c_o        = 1'b1;
                end
                OPCODE_LOAD: begin
                    ctrl_c_o.mem_read   = 1'b1;
                    ctrl_c_o.reg_write  = 1'b1;
                    ctrl_c_o.alu_src_2  = 1'b1;
                    ctrl_c_o.alu_op     = ALUOP_ADD;
                    ctrl_c_o.mem_to_reg = MEMTOREG_MEM;
                    uses_rs1_c_o        = 1'b1;
                end
                OPCODE_STORE: begin
                    ctrl_c_o.mem_write  = 1'b1;
                    ctrl_c_o.alu_src_2  = 1'b1;
                    ctrl_c_o.alu_op     = ALUOP_ADD;
                    uses_rs1_c_o        = 1'b1;
                    uses_rs2_c_o        = 1'b1;
                end
                OPCODE_BRANCH: begin
                    ctrl_c_o.branch     = 1'b1;
                    ctrl_c_o.alu_op     = ALUOP_BRANCH;
                    uses_rs1_c_o        = 1'b1;
                    uses_rs2_c_o        = 1'b1;
                end
                OPCODE_JAL: begin
                    ctrl_c_o.jump       = 1'b1;
                    ctrl_c_o.reg_write  = 1'b1;
                    ctrl_c_o.alu_src_1  = 1'b1;
                    ctrl_c_o.alu_src_2  = 1'b1;
                    ctrl_c_o.mem_to_reg = MEMTOREG_PC4;
                end
                OPCODE_JALR: begin
                    ctrl_c_o.jump       = 1'b1;
                    ctrl_c_o.reg_write  = 1'b1;
                    ctrl_c_o.alu_src_2  = 1'b1;
                    ctrl_c_o.mem_to_reg = MEMTOREG_PC4;
                    uses_rs1_c_o        = 1'b1;
                end
                OPCODE_LUI: begin
                    ctrl_c_o.reg_write  = 1'b1;
                    ctrl_c_o.alu_src_2  = 1'b1;
                    ctrl_c_o.alu_op     = ALUOP_ADD;
                end
                OPCODE_AUIPC: begin
                    ctrl_c_o.reg_write  = 1'b1;
                    ctrl_c_o.alu_src_1  = 1'b1;
                    ctrl_c_o.alu_src_2  = 1'b1;
                    ctrl_c_o.alu_op     = ALUOP_ADD;
                end
                OPCODE_SYSTEM: begin
                    // Control word stays NOP; only the halt tag is raised.
                    if (HALT_EN && (funct3_i == 3'b000)) begin
                        is_halt_c_o = 1'b1;
                    end
                end
                OPCODE_FENCE: begin
                    ctrl_c_o = ctrl_nop();
                end
                default: begin
                    ctrl_c_o = ctrl_nop();
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_unit
// Pipelined control unit for the 5-stage femtoRV32 core. Decodes ID, carries
// the control word through ID/EX, EX/MEM and MEM/WB, detects load-use hazards,
// applies EX flushes and tracks ECALL/EBREAK halt until it retires in WB.
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   slave side of pipe_ctrl_unit_if (ID fields in, stage controls out)
// ----------------------------------------------------------------------------
module pipe_ctrl_unit
    import pipe_ctrl_unit_pkg::*;
#(
    parameter bit HALT_EN     = 1'b1,
    parameter bit LOAD_USE_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    pipe_ctrl_unit_if.slave   bus
);

    localparam logic [1:0] ST_RUN     = 2'b00;
    localparam logic [1:0] ST_PENDING = 2'b01;
    localparam logic [1:0] ST_HALTED  = 2'b10;

    logic [1:0] state_q, state_d;
    idex_t      idex_q,  idex_d;
    exmem_t     exmem_q, exmem_d;
    memwb_t     memwb_q, memwb_d;

    ctrl_t dec_ctrl;
    logic  dec_uses_rs1;
    logic  dec_uses_rs2;
    logic  dec_is_halt;

    logic  ex_load;
    logic  rs1_hit;
    logic  rs2_hit;
    logic  stall_c;
    logic  fetch_hold_c;
    logic  take_halt;

    pipe_ctrl_unit_ctrl_decoder #(
        .HALT_EN (HALT_EN)
    ) u_dec (
        .valid_i      (bus.id_valid),
        .opcode_i     (bus.id_opcode),
        .funct3_i     (bus.id_funct3),
        .ctrl_c_o     (dec_ctrl),
        .uses_rs1_c_o (dec_uses_rs1),
        .uses_rs2_c_o (dec_uses_rs2),
        .is_halt_c_o  (dec_is_halt)
    );

    // Load-use detection against the instruction currently in EX
    assign ex_load      = idex_q.valid & idex_q.ctrl.mem_read & (idex_q.rd != '0);
    assign rs1_hit      = dec_uses_rs1 & (idex_q.rd == bus.id_rs1);
    assign rs2_hit      = dec_uses_rs2 & (idex_q.rd == bus.id_rs2);
    assign stall_c      = LOAD_USE_EN & ex_load & (rs1_hit | rs2_hit) & ~bus.ex_flush;
    assign fetch_hold_c = (state_q != ST_RUN);
    // A second halt while one is already pending/retired is ignored (bubbled).
    assign take_halt    = dec_is_halt & ~bus.ex_flush & (state_q == ST_RUN);

    // Next-state: stage advance and halt FSM
    always_comb begin
        idex_d  = '0;
        exmem_d = '0;
        memwb_d = '0;
        state_d = state_q;

        // Flush, stall and halt hold all force a bubble into ID/EX.
        if (bus.id_valid && !bus.ex_flush && !stall_c && !fetch_hold_c) begin
            idex_d.valid = 1'b1;
            idex_d.halt  = dec_is_halt;
            idex_d.rd    = bus.id_rd;
            idex_d.ctrl  = dec_ctrl;
        end

        exmem_d.halt       = idex_q.halt;
        exmem_d.rd         = idex_q.rd;
        exmem_d.mem_read   = idex_q.ctrl.mem_read;
        exmem_d.mem_write  = idex_q.ctrl.mem_write;
        exmem_d.reg_write  = idex_q.ctrl.reg_write;
        exmem_d.mem_to_reg = idex_q.ctrl.mem_to_reg;

        memwb_d.halt       = exmem_q.halt;
        memwb_d.rd         = exmem_q.rd;
        memwb_d.reg_write  = exmem_q.reg_write;
        memwb_d.mem_to_reg = exmem_q.mem_to_reg;

        case (state_q)
            ST_RUN:     if (take_halt)    state_d = ST_PENDING;
            ST_PENDING: if (memwb_q.halt) state_d = ST_HALTED;
            ST_HALTED:  state_d = ST_HALTED;
            default:    state_d = ST_RUN;
        endcase
    end

    // Stage registers and FSM state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            state_q <= state_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign bus.stall        = stall_c;
    assign bus.fetch_hold   = fetch_hold_c;
    assign bus.halted       = (state_q == ST_HALTED);
    assign bus.ex_Branch    = idex_q.ctrl.branch;
    assign bus.ex_Jump      = idex_q.ctrl.jump;
    assign bus.ex_ALUSrc_1  = idex_q.ctrl.alu_src_1;
    assign bus.ex_ALUSrc_2  = idex_q.ctrl.alu_src_2;
    assign bus.ex_ALUOp     = idex_q.ctrl.alu_op;
    assign bus.ex_rd        = idex_q.rd;
    assign bus.mem_rd       = exmem_q.rd;
    assign bus.mem_MemRead  = exmem_q.mem_read;
    assign bus.mem_MemWrite = exmem_q.mem_write;
    assign bus.wb_rd        = memwb_q.rd;
    assign bus.wb_RegWrite  = memwb_q.reg_write;
    assign bus.wb_MemtoReg  = memwb_q.mem_to_reg;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// ----------------------------------------------------------------------------
// tb_pipe_ctrl_unit
// Directed stimulus for pipe_ctrl_unit. Each issued instruction that should
// write back pushes {cycle, rd, MemtoReg} into a queue; a monitor pops on every
// wb_RegWrite and flags late, early, missing or unexpected write-backs.
// A second instance with halting disabled shadows the same inputs.
// ----------------------------------------------------------------------------
module tb_pipe_ctrl_unit;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_I      = 5'b00100;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    localparam int M_ALU  = 0;
    localparam int M_MEM  = 1;
    localparam int M_PC4  = 2;
    localparam int NO_WB  = -1;

    typedef struct {
        int cyc;
        int rd;
        int mtr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t exp_q[$];

    pipe_ctrl_unit_if if0 ();
    pipe_ctrl_unit_if if1 ();

    pipe_ctrl_unit #(.HALT_EN(1'b1), .LOAD_USE_EN(1'b1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    pipe_ctrl_unit #(.HALT_EN(1'b0), .LOAD_USE_EN(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    assign if1.id_valid  = if0.id_valid;
    assign if1.id_opcode = if0.id_opcode;
    assign if1.id_funct3 = if0.id_funct3;
    assign if1.id_rs1    = if0.id_rs1;
    assign if1.id_rs2    = if0.id_rs2;
    assign if1.id_rd     = if0.id_rd;
    assign if1.ex_flush  = if0.ex_flush;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Drive one ID cycle just after the edge, then wait for the sampling edge.
    task automatic id_in(input bit v, input logic [4:0] opc, input logic [2:0] f3,
                         input int rs1, input int rs2, input int rd, input bit fl,
                         input int wb_mtr);
        @(posedge clk);
        #1;
        if0.id_valid  = v;
        if0.id_opcode = opc;
        if0.id_funct3 = f3;
        if0.id_rs1    = 5'(rs1);
        if0.id_rs2    = 5'(rs2);
        if0.id_rd     = 5'(rd);
        if0.ex_flush  = fl;
        if (wb_mtr != NO_WB) exp_q.push_back('{cyc + 3, rd, wb_mtr});
        @(negedge clk);
    endtask

    task automatic idle();
        id_in(1'b0, 5'd0, 3'd0, 0, 0, 0, 1'b0, NO_WB);
    endtask

    function automatic int outs(input int which);
        logic [28:0] v;
        if (which == 0)
            v = {if0.stall, if0.fetch_hold, if0.halted, if0.ex_Branch, if0.ex_Jump,
                 if0.ex_ALUSrc_1, if0.ex_ALUSrc_2, if0.ex_ALUOp, if0.ex_rd, if0.mem_rd,
                 if0.wb_rd, if0.mem_MemRead, if0.mem_MemWrite, if0.wb_RegWrite, if0.wb_MemtoReg};
        else
            v = {if1.stall, if1.fetch_hold, if1.halted, if1.ex_Branch, if1.ex_Jump,
                 if1.ex_ALUSrc_1, if1.ex_ALUSrc_2, if1.ex_ALUOp, if1.ex_rd, if1.mem_rd,
                 if1.wb_rd, if1.mem_MemRead, if1.mem_MemWrite, if1.wb_RegWrite, if1.wb_MemtoReg};
        return int'(v);
    endfunction

    // Write-back monitor / scoreboard
    exp_t e;
    always @(negedge clk) begin
        if (if0.wb_RegWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("wb_unexpected_regwrite", int'(if0.wb_RegWrite), 0);
            end else begin
                e = exp_q.pop_front();
                chk("wb_cycle", cyc, e.cyc);
                chk("wb_rd", int'(if0.wb_rd), e.rd);
                chk("wb_memtoreg", int'(if0.wb_MemtoReg), e.mtr);
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            chk("wb_missing_regwrite", int'(if0.wb_RegWrite), 1);
            void'(exp_q.pop_front());
        end
    end

    initial begin
        if0.id_valid  = 1'b0;
        if0.id_opcode = 5'd0;
        if0.id_funct3 = 3'd0;
        if0.id_rs1    = 5'd0;
        if0.id_rs2    = 5'd0;
        if0.id_rd     = 5'd0;
        if0.ex_flush  = 1'b0;

        // Reset: every output zero
        repeat (2) begin
            @(negedge clk);
            chk("reset_outputs_dut0", outs(0), 0);
            chk("reset_outputs_dut1", outs(1), 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        // ADD x3,x1,x2 -> WB 3 cycles later
        id_in(1'b1, OP_R, 3'd0, 1, 2, 3, 1'b0, M_ALU);
        idle();
        chk("add_ex_aluop", int'(if0.ex_ALUOp), 2);
        chk("add_ex_rd", int'(if0.ex_rd), 3);
        chk("add_ex_alusrc2", int'(if0.ex_ALUSrc_2), 0);
        repeat (3) idle();

        // LW x5,0(x1); ADD x6,x5,x2 -> one stall, one bubble in EX
        id_in(1'b1, OP_LOAD, 3'd2, 1, 0, 5, 1'b0, M_MEM);
        chk("lw_no_stall", int'(if0.stall), 0);
        id_in(1'b1, OP_R, 3'd0, 5, 2, 6, 1'b0, NO_WB);
        chk("loaduse_stall", int'(if0.stall), 1);
        chk("loaduse_ex_rd", int'(if0.ex_rd), 5);
        id_in(1'b1, OP_R, 3'd0, 5, 2, 6, 1'b0, M_ALU);
        chk("loaduse_stall_once", int'(if0.stall), 0);
        chk("bubble_ex_rd", int'(if0.ex_rd), 0);
        chk("bubble_ex_aluop", int'(if0.ex_ALUOp), 0);
        chk("lw_mem_memread", int'(if0.mem_MemRead), 1);
        chk("lw_mem_rd", int'(if0.mem_rd), 5);
        repeat (3) idle();

        // LW x0 then use x0: no stall
        id_in(1'b1, OP_LOAD, 3'd2, 1, 0, 0, 1'b0, M_MEM);
        id_in(1'b1, OP_R, 3'd0, 0, 2, 6, 1'b0, M_ALU);
        chk("x0_no_stall", int'(if0.stall), 0);
        repeat (3) idle();

        // LW x5 then LUI x5 / JAL: neither reads rs
        id_in(1'b1, OP_LOAD, 3'd2, 1, 0, 5, 1'b0, M_MEM);
        id_in(1'b1, OP_LUI, 3'd0, 5, 5, 5, 1'b0, M_ALU);
        chk("lui_no_stall", int'(if0.stall), 0);
        id_in(1'b1, OP_LOAD, 3'd2, 1, 0, 5, 1'b0, M_MEM);
        id_in(1'b1, OP_JAL, 3'd0, 5, 5, 1, 1'b0, M_PC4);
        chk("jal_no_stall", int'(if0.stall), 0);
        idle();
        chk("jal_ex_jump", int'(if0.ex_Jump), 1);
        chk("jal_ex_alusrc1", int'(if0.ex_ALUSrc_1), 1);
        repeat (3) idle();

        // LW x5 then SW x5,0(x1): hazard through rs2
        id_in(1'b1, OP_LOAD, 3'd2, 1, 0, 5, 1'b0, M_MEM);
        id_in(1'b1, OP_STORE, 3'd2, 1, 5, 5, 1'b0, NO_WB);
        chk("sw_rs2_stall", int'(if0.stall), 1);
        id_in(1'b1, OP_STORE, 3'd2, 1, 5, 5, 1'b0, NO_WB);
        chk("sw_stall_once", int'(if0.stall), 0);
        idle();
        idle();
        chk("sw_mem_memwrite", int'(if0.mem_MemWrite), 1);
        repeat (3) idle();

        // Flush on top of a load-use hazard: no stall, squashed ADD never writes
        id_in(1'b1, OP_LOAD, 3'd2, 1, 0, 5, 1'b0, M_MEM);
        id_in(1'b1, OP_R, 3'd0, 5, 2, 6, 1'b1, NO_WB);
        chk("flush_kills_stall", int'(if0.stall), 0);
        idle();
        chk("flush_bubble_ex_rd", int'(if0.ex_rd), 0);
        chk("flush_bubble_ex_aluop", int'(if0.ex_ALUOp), 0);
        repeat (3) idle();

        // ECALL squashed by flush: no halt
        id_in(1'b1, OP_SYSTEM, 3'd0, 0, 0, 0, 1'b1, NO_WB);
        idle();
        chk("flushed_ecall_fetch_hold", int'(if0.fetch_hold), 0);
        repeat (4) idle();
        chk("flushed_ecall_halted", int'(if0.halted), 0);
        chk("flushed_ecall_fetch_hold_late", int'(if0.fetch_hold), 0);

        // ADDI x7; ADD x8; ECALL -> older ops retire, then halt
        id_in(1'b1, OP_I, 3'd0, 1, 0, 7, 1'b0, M_ALU);
        id_in(1'b1, OP_R, 3'd0, 1, 2, 8, 1'b0, M_ALU);
        id_in(1'b1, OP_SYSTEM, 3'd0, 0, 0, 0, 1'b0, NO_WB);
        chk("ecall_id_fetch_hold", int'(if0.fetch_hold), 0);
        for (int k = 3; k <= 10; k++) begin
            // younger ADD x9 keeps arriving but must never write back
            id_in(1'b1, OP_R, 3'd0, 1, 2, 9, 1'b0, NO_WB);
            if (k == 3) begin
                chk("pending_fetch_hold", int'(if0.fetch_hold), 1);
                chk("pending_not_halted", int'(if0.halted), 0);
            end
            if (k == 5) chk("ecall_in_wb_not_halted", int'(if0.halted), 0);
            if (k == 6) begin
                chk("halted_after_wb", int'(if0.halted), 1);
                chk("halt_dis_fetch_hold", int'(if1.fetch_hold), 0);
                chk("halt_dis_halted", int'(if1.halted), 0);
            end
            if (k == 10) begin
                chk("halted_sticky", int'(if0.halted), 1);
                chk("halted_fetch_hold", int'(if0.fetch_hold), 1);
            end
        end

        // Only reset clears halt
        @(posedge clk);
        #1;
        rst = 1'b1;
        if0.id_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_clears_halted", int'(if0.halted), 0);
        chk("rst_clears_fetch_hold", int'(if0.fetch_hold), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) idle();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
